// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one full round per clock over a 128-bit state register.
// The expanded key schedule is supplied by the caller and must stay stable while a block is in flight.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  logic [7:0] inv;
  assign inv = ginv(a_i);
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_cipher_iter #(
  parameter int NUM_LANES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plaintext,
  input  logic [1407:0]   word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    ciphertext,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e         state_q, state_d;
  logic [3:0]     ctr_q, ctr_d;
  logic [127:0]   data_q, data_d;

  logic [0:10][127:0]             rk;
  logic [NUM_LANES-1:0][7:0]      sb, sr, mc;
  logic [127:0]                   sr_flat, mc_flat, round_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign rk = word;

  // Lane k is FIPS byte k: row k%4, column k/4, byte 0 in the top bits.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    aes_sbox u_sbox (.a_i(data_q[127-8*k -: 8]), .s_o(sb[k]));
    assign sr[k] = sb[4*(((k/4) + (k%4)) % 4) + (k%4)];
    assign sr_flat[127-8*k -: 8] = sr[k];
    assign mc_flat[127-8*k -: 8] = mc[k];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    assign mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  // Final round skips MixColumns.
  assign round_out = ((ctr_q == 4'd10) ? sr_flat : mc_flat) ^ rk[ctr_q];

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = plaintext ^ rk[0];
        ctr_d   = 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        data_d = round_out;
        if (ctr_q == 4'd10) state_d = DONE;
        else                ctr_d   = ctr_q + 4'd1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= 4'd0;
      data_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      data_q  <= data_d;
    end
  end

  // Gated by rst so an IDLE-held reset does not advertise readiness.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == ROUND) || (state_q == DONE);
  assign ciphertext = data_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors, latency, backpressure, back-to-back, mid-round reset.
module tb_aes_cipher_iter;
  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]  plaintext, ciphertext;
  logic [1407:0] word;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .word(word), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key schedule generation (stimulus only; results are checked against FIPS constants).
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    r = '0;
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (ciphertext !== 128'd0) begin n_bad++; $display("FAIL rst_ct: got %h want 0", ciphertext); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips_b();
    int n;
    word = expand(KEY_B); plaintext = PT_B; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (ciphertext !== R0_B) begin n_bad++; $display("FAIL b_round0: got %h want %h", ciphertext, R0_B); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL b_busy: got rdy=%b busy=%b want 0/1", in_ready, busy); end
    step();
    n = 1;
    n_cmp++; if (ciphertext !== R1_B) begin n_bad++; $display("FAIL b_round1: got %h want %h", ciphertext, R1_B); end
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b_latency: got %0d want 10", n); end
    n_cmp++; if (ciphertext !== CT_B) begin n_bad++; $display("FAIL b_ct: got %h want %h", ciphertext, CT_B); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL b_handshake: got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
    n_cmp++; if (ciphertext !== CT_B) begin n_bad++; $display("FAIL b_hold: got %h want %h", ciphertext, CT_B); end
  endtask

  task automatic test_fips_c();
    int n;
    word = expand(KEY_C); plaintext = PT_C; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL c_latency: got %0d want 10", n); end
    n_cmp++; if (ciphertext !== CT_C) begin n_bad++; $display("FAIL c_ct: got %h want %h", ciphertext, CT_C); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL c_handshake: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    int n;
    word = expand(KEY_B); plaintext = PT_B; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL bp_latency: got %0d want 10", n); end
    for (int i = 0; i < 5; i++) begin
      plaintext = PT_C; in_valid = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b1 || ciphertext !== CT_B) begin n_bad++; $display("FAIL bp_hold%0d: got ov=%b ct=%h want 1/%h", i, out_valid, ciphertext, CT_B); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy%0d: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got ov=%b rdy=%b want 0/1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_noqueue%0d: got busy=%b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    word = expand(KEY_B); plaintext = PT_B; in_valid = 1'b1;
    step();
    plaintext = PT_C;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_lat1: got %0d want 10", n); end
    n_cmp++; if (ciphertext !== CT_B) begin n_bad++; $display("FAIL b2b_ct1: got %h want %h", ciphertext, CT_B); end
    word = expand(KEY_C);
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy1: got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_lat2: got %0d want 10", n); end
    n_cmp++; if (ciphertext !== CT_C) begin n_bad++; $display("FAIL b2b_ct2: got %h want %h", ciphertext, CT_C); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy2: got %b want 1", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    word = expand(KEY_B); plaintext = PT_B; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: got rdy=%b ov=%b busy=%b want 0/0/0", in_ready, out_valid, busy); end
    n_cmp++; if (ciphertext !== 128'd0) begin n_bad++; $display("FAIL mid_rst_ct: got %h want 0", ciphertext); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_noemit%0d: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL mid_rerun_lat: got %0d want 10", n); end
    n_cmp++; if (ciphertext !== CT_B) begin n_bad++; $display("FAIL mid_rerun_ct: got %h want %h", ciphertext, CT_B); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; word = '0;
    test_reset();
    test_fips_b();
    test_fips_c();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: in_valid  input  1  plaintext and key schedule offered.
REQ-005 Port: in_ready  output  1  block idle and able to accept.
REQ-006 Port: plaintext  input  128  FIPS-197 input block; byte 0 = plaintext[127:120], column-major.
REQ-007 Port: word  input  1408  expanded AES-128 key schedule; round key r = word[1407-128*r -: 128], r = 0..10.
REQ-008 Port: out_valid  output  1  ciphertext valid.
REQ-009 Port: out_ready  input  1  downstream accepts ciphertext.
REQ-010 Port: ciphertext  output  128  encrypted block, same byte order as plaintext.
REQ-011 Port: busy  output  1  high in ROUND and DONE.

Function
REQ-012 The state machine SHALL have three states: IDLE, ROUND, DONE.
REQ-013 in_ready SHALL equal (state == IDLE); an accept SHALL be in_valid && in_ready at a rising edge.
REQ-014 On accept, the 128-bit state register SHALL load plaintext XOR round key 0, the round counter SHALL load 1, and the FSM SHALL enter ROUND.
REQ-015 In ROUND, each edge SHALL apply one round: SubBytes (16 instances of the existing 8-bit sbox), ShiftRows, MixColumns, then AddRoundKey with round key r.
REQ-016 When r == 10, MixColumns SHALL be bypassed; the result SHALL load the state register and the FSM SHALL enter DONE.
REQ-017 For r < 10, the round counter SHALL increment by 1 after each round.
REQ-018 Latency: out_valid SHALL rise exactly 10 clock edges after the accept edge.
REQ-019 ciphertext SHALL be driven directly from the state register; it is meaningful only while out_valid is high.
REQ-020 In DONE, out_valid SHALL be high and SHALL stay high, with ciphertext stable, until out_ready is high at an edge.
REQ-021 On out_valid && out_ready at an edge, the FSM SHALL return to IDLE; the state register SHALL hold its value.
REQ-022 in_valid SHALL be ignored in ROUND and DONE; no second block is queued.
REQ-023 The upstream SHALL hold word stable from the accept edge through the edge that enters DONE; the block does not latch word.
REQ-024 The round counter SHALL be 4 bits; values 0 and 11..15 SHALL never occur outside reset.
REQ-025 MixColumns SHALL use xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
REQ-026 The critical path SHALL be one round (sbox + MixColumns + XOR); there SHALL be no other pipelining.

Reset
REQ-027 When rst is asserted, all registers SHALL clear asynchronously: state = IDLE, counter = 0, state register = 0.
REQ-028 While rst is asserted: in_ready = 0, out_valid = 0, busy = 0, ciphertext = 0.
REQ-029 After rst is released, in_ready SHALL be 1 in the first cycle.
REQ-030 A reset asserted mid-round or in DONE SHALL abort the block; no ciphertext SHALL be emitted for it.

Verification
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c expanded to word, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid 10 edges after accept.
REQ-032 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out_valid and ciphertext stay constant; in_ready stays 0; a new in_valid is ignored.
REQ-034 Back-to-back: both vectors offered consecutively with out_ready = 1 -> both ciphertexts correct, in order; each has 10-edge latency; in_ready returns to 1 one cycle after each output handshake.
REQ-035 Reset at round 5: assert rst -> in_ready = 0, out_valid = 0, ciphertext = 0 immediately; after release, in_ready = 1 and a new App. B run gives the correct result.
REQ-036 Round-key check: probe the state register after accept and after round 1 against the App. B intermediates 193de3bea0f4e22b9ac68d2ae9f84808 and a49c7ff2689f352b6b5bea43026a5049.
